// File: rtl/iter_comparator.sv
// rtl/iter_comparator.sv - chunk-serial signed/unsigned magnitude comparator with min/max
module iter_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             unsigned_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o,
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    K_LAST   = KW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             uns_q, uns_d;
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic [WIDTH-1:0] a_orig, b_orig, flip_in, flip_q;

    // Signed operands are stored with the MSB inverted, turning the chunk compare into an unsigned one
    assign flip_in = unsigned_i ? '0 : MSB_MASK;
    assign flip_q  = uns_q ? '0 : MSB_MASK;
    assign chunk_a = a_q[int'(k_q)*CHUNK +: CHUNK];
    assign chunk_b = b_q[int'(k_q)*CHUNK +: CHUNK];
    assign a_orig  = a_q ^ flip_q;
    assign b_orig  = b_q ^ flip_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            uns_q   <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            uns_q   <= uns_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        uns_d   = uns_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        if (flush_i) begin
            state_d = IDLE;
            k_d     = '0;
            lt_d    = 1'b0;
            eq_d    = 1'b0;
            gt_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        a_d     = a_i ^ flip_in;
                        b_d     = b_i ^ flip_in;
                        uns_d   = unsigned_i;
                        k_d     = K_LAST;
                        lt_d    = 1'b0;
                        eq_d    = 1'b0;
                        gt_d    = 1'b0;
                        state_d = CMP;
                    end
                end
                CMP: begin
                    if (chunk_a < chunk_b) begin
                        lt_d    = 1'b1;
                        state_d = DONE;
                    end else if (chunk_a > chunk_b) begin
                        gt_d    = 1'b1;
                        state_d = DONE;
                    end else if (k_q == '0) begin
                        eq_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        k_d = k_q - 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        lt_d    = 1'b0;
                        eq_d    = 1'b0;
                        gt_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign lt_o    = valid_o & lt_q;
    assign eq_o    = valid_o & eq_q;
    assign gt_o    = valid_o & gt_q;
    assign min_o   = valid_o ? ((lt_q | eq_q) ? a_orig : b_orig) : '0;
    assign max_o   = valid_o ? ((lt_q | eq_q) ? b_orig : a_orig) : '0;

endmodule

// File: doc/iter_comparator.md
ITER_COMPARATOR -- requirements
Module: iter_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port valid_i, input, 1, request valid.
REQ-006 The block SHALL have port ready_o, output, 1, block can accept a request.
REQ-007 The block SHALL have ports a_i and b_i, input, WIDTH each, the operands.
REQ-008 The block SHALL have port unsigned_i, input, 1, where 1 = unsigned compare and 0 = two's-complement signed.
REQ-009 The block SHALL have port flush_i, input, 1, synchronous abort of any request.
REQ-010 The block SHALL have port valid_o, input-side naming aside, output, 1, result valid.
REQ-011 The block SHALL have port ready_i, input, 1, consumer accepts the result.
REQ-012 The block SHALL have ports lt_o, eq_o and gt_o, output, 1 each, a<b, a==b and a>b respectively.
REQ-013 The block SHALL have ports min_o and max_o, output, WIDTH each, the smaller and the larger original operand under the selected mode.

Function
REQ-014 The FSM SHALL have states IDLE, CMP and DONE; ready_o = 1 only in IDLE and valid_o = 1 only in DONE.
REQ-015 In IDLE with valid_i=1 at an edge, the block SHALL latch a_i, b_i and unsigned_i, set chunk index k=N-1, and go to CMP.
REQ-016 For a signed request, operand MSBs SHALL be inverted at latch time so that an unsigned chunk compare yields the signed ordering; min_o/max_o SHALL return the original, uninverted values.
REQ-017 In CMP, each edge SHALL compare chunk k of both latched operands, MSB chunk first.
REQ-018 In CMP, if the chunks differ, the block SHALL set lt or gt accordingly and go to DONE (early termination).
REQ-019 In CMP, if the chunks are equal and k=0, the block SHALL set eq and go to DONE; otherwise it SHALL decrement k and stay in CMP.
REQ-020 Latency SHALL be: valid_o rises after edge N-j following the accept edge, where j is the index of the most significant differing chunk; for equal operands, after edge N.
REQ-021 Exactly one of lt_o, eq_o and gt_o SHALL be 1 while valid_o=1.
REQ-022 For equal operands, min_o = max_o = a.
REQ-023 In DONE, all result outputs SHALL hold stable until valid_o && ready_i, then the FSM SHALL go to IDLE; there is no overlap, and a new request is accepted no earlier than the following edge.
REQ-024 valid_i SHALL be ignored outside IDLE, and ready_i SHALL be ignored outside DONE.
REQ-025 flush_i=1 at an edge SHALL force IDLE and clear the result outputs, with priority over every other transition, including a simultaneous valid_i in IDLE, which is not accepted.
REQ-026 For CHUNK=WIDTH, the block SHALL decide in one CMP cycle, with valid_o high after edge 1.
REQ-027 Result outputs SHALL be 0 when valid_o=0.

Reset
REQ-028 While rst_ni=0, the state SHALL be IDLE with ready_o=1, and valid_o, lt_o, eq_o, gt_o, min_o, max_o, k and the latched operands all 0, independent of clk_i.
REQ-029 Reset asserted mid-CMP or mid-DONE SHALL discard the request; after release, no valid_o is produced for it.

Verification (WIDTH=32, CHUNK=8 unless noted)
REQ-030 The bench SHALL check: unsigned a=0x12345678, b=0x12345679 -> valid_o after edge 4, lt_o=1, min_o=0x12345678, max_o=0x12345679.
REQ-031 The bench SHALL check: signed a=0x80000000, b=0x00000001 -> valid_o after edge 1, lt_o=1; the same operands unsigned -> gt_o=1, max_o=0x80000000.
REQ-032 The bench SHALL check: signed a=b=0xFFFFFFFF -> valid_o after edge 4, eq_o=1, min_o=max_o=0xFFFFFFFF.
REQ-033 The bench SHALL check: result held with ready_i=0 for 5 cycles -> outputs stable; ready_i=1 -> IDLE; the next request is accepted one edge later.
REQ-034 The bench SHALL check: flush_i pulse during CMP -> IDLE next edge with valid_o never asserted; rst_ni low during DONE -> outputs 0 immediately.
REQ-035 The bench SHALL check: WIDTH=16, CHUNK=16, signed a=0xFFFE, b=0xFFFF -> valid_o after edge 1, lt_o=1.
